// File: rtl/mac_tx_scheduler.sv
// Round-robin TX scheduler: arbitrates NUM_REQ sources onto one frame generator,
// then streams the generated frame as 64-bit beats followed by an inter-packet gap.
module mac_tx_scheduler #(
  parameter int NUM_REQ          = 4,
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int FRAME_BITS       = PAYLOAD_MAX_SIZE*8+208,
  parameter int IPG_CYCLES       = 2,
  parameter int DONE_TIMEOUT     = 16
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [NUM_REQ*48-1:0]   i_dest_address,
  input  logic [NUM_REQ*48-1:0]   i_src_address,
  input  logic [NUM_REQ*16-1:0]   i_payload_length,
  input  logic [NUM_REQ*8-1:0]    i_mode,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [NUM_REQ-1:0]      o_sent,
  output logic                    o_gen_start,
  output logic [47:0]             o_gen_dest_address,
  output logic [47:0]             o_gen_src_address,
  output logic [15:0]             o_gen_payload_length,
  output logic [7:0]              o_gen_mode,
  input  logic                    i_gen_done,
  input  logic [FRAME_BITS-1:0]   i_gen_register,
  output logic [63:0]             o_tx_data,
  output logic [7:0]              o_tx_keep,
  output logic                    o_tx_valid,
  output logic                    o_tx_last,
  input  logic                    i_tx_ready,
  output logic                    o_busy,
  output logic                    o_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NB = (FRAME_BITS + 63) / 64;

  typedef enum logic [2:0] {IDLE, ARB, START, STREAM, IPG} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]    last_grant, owner, pick;
  logic             pick_vld, tmo;
  logic [15:0]      cnt, sel_len, plen;
  logic [7:0]       sel_mode, keep_last, keep_last_c;
  logic [10:0]      fbytes;
  logic [8:0]       nbeats, last_m1, idx, sel_idx;
  logic [NB*64-1:0] reg_pad;
  logic [63:0]      beat_sel;

  // Round-robin search starting just above the previous owner
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_vld && i_req[(int'(last_grant) + i) % NUM_REQ]) begin
        pick     = IW'((int'(last_grant) + i) % NUM_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  // Frame geometry of the candidate owner: padded payload + 26 overhead bytes
  always_comb begin
    sel_len  = i_payload_length[16*int'(pick) +: 16];
    sel_mode = i_mode[8*int'(pick) +: 8];
    plen     = (sel_len > 16'(PAYLOAD_MAX_SIZE)) ? 16'(PAYLOAD_MAX_SIZE) : sel_len;
    if (sel_mode != 8'd2 && plen < 16'd46) plen = 16'd46;
    fbytes      = 11'(plen + 16'd26);
    nbeats      = 9'((12'(fbytes) + 12'd7) >> 3);
    keep_last_c = (fbytes[2:0] == 3'd0) ? 8'hFF : ~(8'hFF << fbytes[2:0]);
  end

  always_comb begin
    reg_pad                   = '0;
    reg_pad[FRAME_BITS-1:0]   = i_gen_register;
    sel_idx                   = (state == STREAM) ? idx + 9'd1 : 9'd0;
    beat_sel                  = reg_pad[64*int'(sel_idx) +: 64];
  end

  assign tmo = i_gen_done && (cnt == 16'(DONE_TIMEOUT-1));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (|i_req) state_nxt = ARB;
      ARB:    state_nxt = pick_vld ? START : IDLE;
      START:  if (!i_gen_done) state_nxt = STREAM;
              else if (tmo)    state_nxt = IPG;
      STREAM: if (i_tx_ready && o_tx_last) state_nxt = IPG;
      IPG:    if (cnt == 16'(IPG_CYCLES-1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy      = (state != IDLE);
  assign o_tx_valid  = (state == STREAM);
  assign o_gen_start = (state == START) || (state == STREAM);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant           <= IW'(NUM_REQ-1);
      owner                <= '0;
      o_grant              <= '0;
      o_sent               <= '0;
      o_err                <= 1'b0;
      o_gen_dest_address   <= '0;
      o_gen_src_address    <= '0;
      o_gen_payload_length <= '0;
      o_gen_mode           <= '0;
      keep_last            <= '0;
      last_m1              <= '0;
      idx                  <= '0;
      cnt                  <= '0;
      o_tx_data            <= '0;
      o_tx_keep            <= '0;
      o_tx_last            <= 1'b0;
    end else begin
      o_sent <= '0;
      o_err  <= 1'b0;
      cnt    <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
      case (state)
        ARB: if (pick_vld) begin
          owner                <= pick;
          o_grant              <= NUM_REQ'(1) << pick;
          o_gen_dest_address   <= i_dest_address[48*int'(pick) +: 48];
          o_gen_src_address    <= i_src_address[48*int'(pick) +: 48];
          o_gen_payload_length <= sel_len;
          o_gen_mode           <= sel_mode;
          keep_last            <= keep_last_c;
          last_m1              <= nbeats - 9'd1;
        end
        START: if (!i_gen_done) begin
          idx       <= '0;
          o_tx_data <= beat_sel;
          o_tx_last <= (last_m1 == 9'd0);
          o_tx_keep <= (last_m1 == 9'd0) ? keep_last : 8'hFF;
        end else if (tmo) begin
          o_err      <= 1'b1;
          o_grant    <= '0;
          last_grant <= owner;
        end
        STREAM: if (i_tx_ready) begin
          if (o_tx_last) begin
            o_sent     <= o_grant;
            o_grant    <= '0;
            last_grant <= owner;
            o_tx_data  <= '0;
            o_tx_keep  <= '0;
            o_tx_last  <= 1'b0;
          end else begin
            idx       <= idx + 9'd1;
            o_tx_data <= beat_sel;
            o_tx_last <= (idx + 9'd1 == last_m1);
            o_tx_keep <= (idx + 9'd1 == last_m1) ? keep_last : 8'hFF;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_tx_scheduler.sv
// Directed bench for mac_tx_scheduler with a behavioural frame-generator model.
module tb_mac_tx_scheduler;
  localparam int NREQ = 4;
  localparam int PMAX = 1500;
  localparam int FB   = PMAX*8+208;
  localparam int IPG  = 2;
  localparam int TMO  = 16;

  logic                clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic [NREQ-1:0]     i_req = '0;
  logic [NREQ*48-1:0]  i_dest_address = '0, i_src_address = '0;
  logic [NREQ*16-1:0]  i_payload_length = '0;
  logic [NREQ*8-1:0]   i_mode = '0;
  logic [NREQ-1:0]     o_grant, o_sent;
  logic                o_gen_start, i_gen_done, o_tx_valid, o_tx_last, o_busy, o_err;
  logic                i_tx_ready = 1'b1;
  logic [47:0]         o_gen_dest_address, o_gen_src_address;
  logic [15:0]         o_gen_payload_length;
  logic [7:0]          o_gen_mode, o_tx_keep;
  logic [FB-1:0]       i_gen_register = '0;
  logic [63:0]         o_tx_data;
  logic                force_done = 1'b0;

  int n_tests = 0, n_fail = 0;

  mac_tx_scheduler #(.NUM_REQ(NREQ), .PAYLOAD_MAX_SIZE(PMAX), .FRAME_BITS(FB),
                     .IPG_CYCLES(IPG), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_req(i_req),
    .i_dest_address(i_dest_address), .i_src_address(i_src_address),
    .i_payload_length(i_payload_length), .i_mode(i_mode),
    .o_grant(o_grant), .o_sent(o_sent), .o_gen_start(o_gen_start),
    .o_gen_dest_address(o_gen_dest_address), .o_gen_src_address(o_gen_src_address),
    .o_gen_payload_length(o_gen_payload_length), .o_gen_mode(o_gen_mode),
    .i_gen_done(i_gen_done), .i_gen_register(i_gen_register),
    .o_tx_data(o_tx_data), .o_tx_keep(o_tx_keep), .o_tx_valid(o_tx_valid),
    .o_tx_last(o_tx_last), .i_tx_ready(i_tx_ready), .o_busy(o_busy), .o_err(o_err));

  always #5 clk = ~clk;

  // Generator model: done idles high and drops the cycle after start is seen
  always @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) i_gen_done <= 1'b1;
    else          i_gen_done <= force_done | ~o_gen_start;

  // Captured per-frame observations
  logic [63:0]     got_data [0:255];
  logic [7:0]      got_keep [0:255];
  logic            got_last [0:255];
  int              n_got, lat, stall_bad, sent_cnt;
  logic [NREQ-1:0] grant_seen, sent_seen;
  logic [47:0]     dest_seen;

  function automatic logic [63:0] exp_beat(input int b, input int seed);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 8; j++)
      if (8*b + j < FB/8) v[8*j +: 8] = 8'((8*b + j)*5 + seed);
    return v;
  endfunction

  task automatic load_pattern(input int seed);
    for (int k = 0; k < FB/8; k++) i_gen_register[8*k +: 8] = 8'(k*5 + seed);
  endtask

  task automatic set_req(input int idx, input logic [15:0] len, input logic [7:0] mode);
    i_payload_length[16*idx +: 16] = len;
    i_mode[8*idx +: 8]             = mode;
  endtask

  task automatic run_frame(input int idx, input bit rnd);
    int cyc;
    bit stalled;
    logic [72:0] prev;
    i_req = '0; i_tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    i_req[idx] = 1'b1;
    lat = 0; n_got = 0; stall_bad = 0; sent_cnt = 0; cyc = 0; stalled = 0; prev = '0;
    grant_seen = '0; sent_seen = '0; dest_seen = '0;
    while (sent_cnt == 0 && cyc < 800) begin
      @(negedge clk); cyc++;
      i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_grant != '0 && grant_seen == '0) begin
        grant_seen = o_grant; dest_seen = o_gen_dest_address; i_req = '0;
      end
      if (o_tx_valid) begin
        if (lat == 0) lat = cyc;
        if (stalled && {o_tx_data, o_tx_keep, o_tx_last} !== prev) stall_bad++;
        stalled = !i_tx_ready;
        prev    = {o_tx_data, o_tx_keep, o_tx_last};
        if (i_tx_ready && n_got < 256) begin
          got_data[n_got] = o_tx_data; got_keep[n_got] = o_tx_keep;
          got_last[n_got] = o_tx_last; n_got++;
        end
      end
      if (o_sent != '0) begin sent_seen = o_sent; sent_cnt++; end
    end
    @(negedge clk);
    if (o_sent != '0) sent_cnt++;
    i_tx_ready = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if ({o_grant, o_sent, o_gen_start, o_tx_valid, o_tx_last, o_busy, o_err} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0",
        {o_grant, o_sent, o_gen_start, o_tx_valid, o_tx_last, o_busy, o_err});
    end
    n_tests++;
    if ({o_tx_keep, o_tx_data} !== '0) begin
      n_fail++; $display("FAIL reset_tx got %h want 0", {o_tx_keep, o_tx_data});
    end
    n_tests++;
    if ({o_gen_dest_address, o_gen_src_address, o_gen_payload_length, o_gen_mode} !== '0) begin
      n_fail++; $display("FAIL reset_gen got %h want 0",
        {o_gen_dest_address, o_gen_src_address, o_gen_payload_length, o_gen_mode});
    end
    @(negedge clk); i_rst_n = 1'b1;
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] gseq [5];
    logic [NREQ-1:0] want [5];
    logic [NREQ-1:0] pg;
    int cyc, ng, n_sent, last_acc, min_gap;
    bit waiting;
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b1000; want[3] = 4'b0001; want[4] = 4'b0010;
    for (int i = 0; i < 5; i++) gseq[i] = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'd8, 8'd2);
    cyc = 0; ng = 0; n_sent = 0; last_acc = -1; min_gap = 1000; waiting = 0; pg = '0;
    i_tx_ready = 1'b1;
    i_req = 4'b1011;
    while (n_sent < 5 && cyc < 600) begin
      @(negedge clk); cyc++;
      if (o_grant != '0 && pg == '0) begin
        if (ng < 5) gseq[ng] = o_grant;
        ng++;
        if (ng == 5) i_req = '0;
      end
      pg = o_grant;
      if (o_tx_valid && waiting) begin
        if (cyc - last_acc - 1 < min_gap) min_gap = cyc - last_acc - 1;
        waiting = 0;
      end
      if (o_tx_valid && o_tx_last && i_tx_ready) begin last_acc = cyc; waiting = 1; end
      if (o_sent != '0) n_sent++;
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (gseq[i] !== want[i]) begin
        n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", i, gseq[i], want[i]);
      end
    end
    n_tests++;
    if (n_sent != 5) begin n_fail++; $display("FAIL rr_sent_count got %0d want 5", n_sent); end
    n_tests++;
    if (min_gap < IPG) begin n_fail++; $display("FAIL rr_gap got %0d want >= %0d", min_gap, IPG); end
  endtask

  task automatic test_basic;
    load_pattern(11);
    set_req(0, 16'd8, 8'd0);
    run_frame(0, 1'b0);
    n_tests++;
    if (lat != 4) begin n_fail++; $display("FAIL basic_latency got %0d want 4", lat); end
    n_tests++;
    if (grant_seen !== 4'b0001) begin n_fail++; $display("FAIL basic_grant got %b want 0001", grant_seen); end
    n_tests++;
    if (dest_seen !== 48'hDA00_0000_0000) begin
      n_fail++; $display("FAIL basic_dest got %h want da0000000000", dest_seen);
    end
    n_tests++;
    if (n_got != 9) begin n_fail++; $display("FAIL basic_beats got %0d want 9", n_got); end
    for (int b = 0; b < 9 && b < n_got; b++) begin
      n_tests++;
      if ({got_data[b], got_keep[b], got_last[b]} !== {exp_beat(b, 11), 8'hFF, b == 8}) begin
        n_fail++; $display("FAIL basic_beat[%0d] got %h/%h/%b want %h/ff/%b", b,
          got_data[b], got_keep[b], got_last[b], exp_beat(b, 11), b == 8);
      end
    end
    n_tests++;
    if (sent_seen !== 4'b0001 || sent_cnt != 1) begin
      n_fail++; $display("FAIL basic_sent got %b x%0d want 0001 x1", sent_seen, sent_cnt);
    end
  endtask

  task automatic test_lengths;
    logic [15:0] lens [3];
    logic [7:0]  modes [3], kl [3];
    int          ws [3];
    lens[0] = 16'd8;    modes[0] = 8'd2; ws[0] = 5;   kl[0] = 8'h03;
    lens[1] = 16'd55;   modes[1] = 8'd0; ws[1] = 11;  kl[1] = 8'h01;
    lens[2] = 16'd3000; modes[2] = 8'd0; ws[2] = 191; kl[2] = 8'h3F;
    for (int t = 0; t < 3; t++) begin
      load_pattern(20 + t);
      set_req(2, lens[t], modes[t]);
      run_frame(2, 1'b0);
      n_tests++;
      if (n_got != ws[t]) begin n_fail++; $display("FAIL len%0d_beats got %0d want %0d", t, n_got, ws[t]); end
      n_tests++;
      if (n_got > 0 && {got_keep[n_got-1], got_last[n_got-1]} !== {kl[t], 1'b1}) begin
        n_fail++; $display("FAIL len%0d_lastkeep got %h/%b want %h/1", t,
          got_keep[n_got-1], got_last[n_got-1], kl[t]);
      end
      n_tests++;
      if (n_got > 0 && got_data[n_got-1] !== exp_beat(ws[t]-1, 20 + t)) begin
        n_fail++; $display("FAIL len%0d_lastdata got %h want %h", t,
          got_data[n_got-1], exp_beat(ws[t]-1, 20 + t));
      end
      n_tests++;
      if (sent_seen !== 4'b0100) begin n_fail++; $display("FAIL len%0d_sent got %b want 0100", t, sent_seen); end
    end
  endtask

  task automatic test_backpressure;
    load_pattern(77);
    set_req(0, 16'd8, 8'd0);
    run_frame(0, 1'b1);
    n_tests++;
    if (n_got != 9) begin n_fail++; $display("FAIL bp_beats got %0d want 9", n_got); end
    for (int b = 0; b < 9 && b < n_got; b++) begin
      n_tests++;
      if (got_data[b] !== exp_beat(b, 77)) begin
        n_fail++; $display("FAIL bp_beat[%0d] got %h want %h", b, got_data[b], exp_beat(b, 77));
      end
    end
    n_tests++;
    if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", stall_bad); end
    n_tests++;
    if (sent_cnt != 1) begin n_fail++; $display("FAIL bp_sent got %0d want 1", sent_cnt); end
  endtask

  task automatic test_timeout;
    int n_err, n_vld, n_snt;
    bit gnt_on_err;
    bit got_gnt;
    n_err = 0; n_vld = 0; n_snt = 0; gnt_on_err = 0; got_gnt = 0;
    repeat (4) @(negedge clk);
    force_done = 1'b1;
    i_req = 4'b1000;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o_grant != '0) begin got_gnt = 1; i_req = '0; end
      if (o_err) begin n_err++; if (o_grant != '0) gnt_on_err = 1; end
      if (o_tx_valid) n_vld++;
      if (o_sent != '0) n_snt++;
    end
    i_req = '0;
    force_done = 1'b0;
    n_tests++;
    if (!got_gnt) begin n_fail++; $display("FAIL tmo_grant got 0 want 1"); end
    n_tests++;
    if (n_err != 1) begin n_fail++; $display("FAIL tmo_err got %0d pulses want 1", n_err); end
    n_tests++;
    if (n_vld != 0 || n_snt != 0) begin
      n_fail++; $display("FAIL tmo_quiet got valid %0d sent %0d want 0 0", n_vld, n_snt);
    end
    n_tests++;
    if (gnt_on_err) begin n_fail++; $display("FAIL tmo_grant_drop got grant with err want none"); end
    load_pattern(5);
    set_req(0, 16'd8, 8'd2);
    run_frame(0, 1'b0);
    n_tests++;
    if (n_got != 5 || sent_seen !== 4'b0001) begin
      n_fail++; $display("FAIL tmo_recover got %0d beats sent %b want 5 0001", n_got, sent_seen);
    end
  endtask

  task automatic test_reset_mid;
    int acc, cyc;
    logic [NREQ-1:0] g;
    set_req(1, 16'd8, 8'd0);
    repeat (4) @(negedge clk);
    i_tx_ready = 1'b1;
    i_req = 4'b0010;
    acc = 0; cyc = 0;
    while (acc < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (o_grant != '0) i_req = '0;
      if (o_tx_valid && i_tx_ready) acc++;
    end
    @(negedge clk);
    #1 i_rst_n = 1'b0;
    #1;
    n_tests++;
    if (acc != 4) begin n_fail++; $display("FAIL rst_mid_reach got %0d beats want 4", acc); end
    n_tests++;
    if ({o_grant, o_sent, o_gen_start, o_tx_valid, o_tx_last, o_busy, o_err} !== '0) begin
      n_fail++; $display("FAIL rst_mid_ctrl got %b want 0",
        {o_grant, o_sent, o_gen_start, o_tx_valid, o_tx_last, o_busy, o_err});
    end
    n_tests++;
    if ({o_tx_keep, o_tx_data, o_gen_dest_address} !== '0) begin
      n_fail++; $display("FAIL rst_mid_data got %h want 0", {o_tx_keep, o_tx_data, o_gen_dest_address});
    end
    @(negedge clk); i_rst_n = 1'b1;
    i_req = 4'b1111;
    g = '0; cyc = 0;
    while (g == '0 && cyc < 50) begin
      @(negedge clk); cyc++;
      if (o_sent != '0) g = 4'b1111;
      else g = o_grant;
    end
    i_req = '0;
    n_tests++;
    if (g !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_first_grant got %b want 0001", g); end
    cyc = 0;
    while (o_sent == '0 && cyc < 100) begin @(negedge clk); cyc++; end
    n_tests++;
    if (o_sent !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_finish got %b want 0001", o_sent); end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      i_dest_address[48*i +: 48] = 48'hDA00_0000_0000 | 48'(i);
      i_src_address[48*i +: 48]  = 48'h5A00_0000_0000 | 48'(i);
    end
    test_reset;
    test_round_robin;
    test_basic;
    test_lengths;
    test_backpressure;
    test_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_tests, n_fail);
    $finish;
  end
endmodule
